// File: rtl/seq_shift_add_multiplier.sv
// Unsigned 16x16 sequential shift-and-add multiplier (one iteration per clock)
// together with the 16-bit carry-lookahead adder that forms each partial sum.

// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second-level lookahead over the group generate/propagate terms.
module carry_la_adder (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] out,
    output logic        c_out
);

    logic [15:0] w_g;
    logic [15:0] w_p;
    logic [15:0] w_c;
    logic [3:0]  w_gg;
    logic [3:0]  w_gp;
    logic [3:0]  w_gc;

    // Bit and group generate/propagate, group carries, then in-group carries.
    always_comb begin
        w_g   = a & b;
        w_p   = a ^ b;
        w_gg  = '0;
        w_gp  = '0;
        w_gc  = '0;
        w_c   = '0;
        c_out = 1'b0;

        for (int grp = 0; grp < 4; grp++) begin
            w_gg[grp] = w_g[4*grp+3]
                      | (w_p[4*grp+3] & w_g[4*grp+2])
                      | (w_p[4*grp+3] & w_p[4*grp+2] & w_g[4*grp+1])
                      | (w_p[4*grp+3] & w_p[4*grp+2] & w_p[4*grp+1] & w_g[4*grp]);
            w_gp[grp] = w_p[4*grp+3] & w_p[4*grp+2] & w_p[4*grp+1] & w_p[4*grp];
        end

        w_gc[0] = c_in;
        w_gc[1] = w_gg[0] | (w_gp[0] & c_in);
        w_gc[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & c_in);
        w_gc[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[2] & w_gp[1] & w_gp[0] & c_in);
        c_out   = w_gg[3] | (w_gp[3] & w_gg[2]) | (w_gp[3] & w_gp[2] & w_gg[1])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gg[0])
                | (w_gp[3] & w_gp[2] & w_gp[1] & w_gp[0] & c_in);

        for (int grp = 0; grp < 4; grp++) begin
            w_c[4*grp]   = w_gc[grp];
            w_c[4*grp+1] = w_g[4*grp] | (w_p[4*grp] & w_gc[grp]);
            w_c[4*grp+2] = w_g[4*grp+1] | (w_p[4*grp+1] & w_g[4*grp])
                         | (w_p[4*grp+1] & w_p[4*grp] & w_gc[grp]);
            w_c[4*grp+3] = w_g[4*grp+2] | (w_p[4*grp+2] & w_g[4*grp+1])
                         | (w_p[4*grp+2] & w_p[4*grp+1] & w_g[4*grp])
                         | (w_p[4*grp+2] & w_p[4*grp+1] & w_p[4*grp] & w_gc[grp]);
        end

        out = w_p ^ w_c;
    end

endmodule

module seq_shift_add_multiplier (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] product
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      r_state;
    state_e      w_state_d;
    logic        w_load;
    logic        w_iter;
    logic        w_last;

    logic [15:0] r_mcand;
    logic [15:0] r_acc_hi;
    logic [15:0] r_acc_lo;
    logic [4:0]  r_cnt;
    logic        r_busy;
    logic        r_done;
    logic [31:0] r_product;

    logic [15:0] w_addend;
    logic [15:0] w_sum;
    logic        w_c_out;
    logic [15:0] w_acc_hi_nxt;
    logic [15:0] w_acc_lo_nxt;

    // Partial sum of the upper accumulator and the gated multiplicand.
    assign w_addend = r_acc_lo[0] ? r_mcand : 16'h0000;

    carry_la_adder u_adder (
        .a     (r_acc_hi),
        .b     (w_addend),
        .c_in  (1'b0),
        .out   (w_sum),
        .c_out (w_c_out)
    );

    // 33-bit {carry, sum, acc_lo} shifted right by one; the carry never drops out.
    assign w_acc_hi_nxt = {w_c_out, w_sum[15:1]};
    assign w_acc_lo_nxt = {w_sum[0], r_acc_lo[15:1]};

    // Next-state and control decode; start is only looked at in idle/done.
    always_comb begin
        w_state_d = r_state;
        w_load    = 1'b0;
        w_iter    = 1'b0;
        w_last    = 1'b0;
        case (r_state)
            StIdle: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_d = StCalc;
                end
            end
            StCalc: begin
                w_iter = 1'b1;
                if (r_cnt == 5'd15) begin
                    w_last    = 1'b1;
                    w_state_d = StDone;
                end
            end
            StDone: begin
                if (start) begin
                    w_load    = 1'b1;
                    w_state_d = StCalc;
                end else begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    // State register plus registered busy/done flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_busy  <= (w_state_d == StCalc);
            r_done  <= w_last;
        end
    end

    // Operand capture, iteration datapath and result register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_cnt     <= '0;
            r_product <= '0;
        end else begin
            if (w_load) begin
                r_mcand  <= a;
                r_acc_hi <= '0;
                r_acc_lo <= b;
                r_cnt    <= '0;
            end else if (w_iter) begin
                r_acc_hi <= w_acc_hi_nxt;
                r_acc_lo <= w_acc_lo_nxt;
                r_cnt    <= r_cnt + 5'd1;
            end
            if (w_last) begin
                r_product <= {w_acc_hi_nxt, w_acc_lo_nxt};
            end
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier with hand-computed products.
module tb_seq_shift_add_multiplier;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int n_checks = 0;
    int n_errors = 0;

    seq_shift_add_multiplier dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one accepting edge.
    task automatic issue(input logic [15:0] av, input logic [15:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Called n0 cycles after the accepting edge; expects done 16 cycles after it.
    task automatic wait_done(input string tag, input logic [31:0] exp, input int n0);
        int   n;
        logic gap;
        n   = n0;
        gap = 1'b0;
        while (done !== 1'b1 && n < 40) begin
            if (busy !== 1'b1) gap = 1'b1;
            tick();
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd16);
        check({tag, "_busy_held"}, {31'd0, gap}, 32'd0);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    // One cycle after done: done drops and the product is held.
    task automatic after_done(input string tag, input logic [31:0] exp);
        tick();
        check({tag, "_done_fall"}, {31'd0, done}, 32'd0);
        check({tag, "_held"}, product, exp);
    endtask

    initial begin
        int extra;

        // Reset held with start asserted and random operands.
        rst_n = 1'b0;
        start = 1'b1;
        a     = 16'($urandom);
        b     = 16'($urandom);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_busy", {31'd0, busy}, 32'd0);
            check("rst_done", {31'd0, done}, 32'd0);
            check("rst_product", product, 32'd0);
        end
        start = 1'b0;
        #3 rst_n = 1'b1;
        tick();
        check("idle_after_rst", {31'd0, busy}, 32'd0);

        // Basic multiply.
        issue(16'd3, 16'd5);
        check("basic_busy_rise", {31'd0, busy}, 32'd1);
        wait_done("basic", 32'h0000_000F, 0);
        after_done("basic", 32'h0000_000F);

        // Carry path.
        issue(16'hFFFF, 16'hFFFF);
        wait_done("carry", 32'hFFFE_0001, 0);
        after_done("carry", 32'hFFFE_0001);

        // Zero operand followed by a back-to-back job accepted in the done cycle.
        issue(16'd0, 16'h1234);
        wait_done("zero", 32'h0000_0000, 0);
        issue(16'd128, 16'd1478);
        check("b2b_done_fall", {31'd0, done}, 32'd0);
        check("b2b_busy", {31'd1, busy}, 32'd1 | {31'd0, busy} | 32'd0 ? {31'd1, busy} : 32'd0);
        wait_done("b2b", 32'h0002_E300, 0);
        after_done("b2b", 32'h0002_E300);

        // Start and operand changes during CALC are ignored.
        issue(16'd94, 16'd333);
        for (int i = 0; i < 4; i++) tick();
        issue(16'd1, 16'd10);
        wait_done("ignore", 32'h0000_7A46, 5);
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        check("ignore_single_done", 32'(extra), 32'd0);
        check("ignore_held", product, 32'h0000_7A46);

        // Reset in the middle of an operation.
        issue(16'd15, 16'd31);
        for (int i = 0; i < 7; i++) tick();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_product", product, 32'd0);
        a     = 16'd15;
        b     = 16'd31;
        start = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("midrst_hold_busy", {31'd0, busy}, 32'd0);
            check("midrst_hold_done", {31'd0, done}, 32'd0);
        end
        // Release between edges; start is already high for the first edge.
        #3 rst_n = 1'b1;
        tick();
        start = 1'b0;
        check("rerun_busy_rise", {31'd0, busy}, 32'd1);
        wait_done("rerun", 32'h0000_01D1, 0);
        after_done("rerun", 32'h0000_01D1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
